fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage and IF/ID pipeline register of the pipelined RV32I CPU.
//  - Owns the PC and issues instruction-memory reads.
//  - Absorbs one response while decode is stalled.
//  - Squashes wrong-path fetches on an EX-stage redirect.
//  - Drives opcode/funct3/funct7 straight into the decode/control stage.
// PARAMETERS
//  RESET_PC  32'h6000_0000  fetch address after reset
//  NOP_INSTR 32'h0000_0013  instruction word presented when IF/ID is empty (addi x0,x0,0)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  imem_read     out  1   read request; held high until imem_resp
//  imem_address  out  32  fetch address; stable while imem_read=1
//  imem_resp     in   1   single-cycle pulse: imem_rdata valid
//  imem_rdata    in   32  instruction word
//  redirect      in   1   EX resolved taken branch/jal/jalr; flush and refetch
//  redirect_pc   in   32  new fetch target (word aligned)
//  id_ready      in   1   decode consumes IF/ID entry this cycle when if_id_valid=1
//  if_id_valid   out  1   IF/ID holds a live instruction
//  if_id_pc      out  32  PC of IF/ID instruction
//  if_id_instr   out  32  IF/ID instruction word (NOP_INSTR when invalid)
//  opcode        out  7   if_id_instr[6:0] as rv32i_opcode
//  funct3        out  3   if_id_instr[14:12]
//  funct7        out  7   if_id_instr[31:25]
// BEHAVIOUR
//  Reset (rst=1 at an edge; overrides all other inputs):
//   - state=FETCH, pc_q=RESET_PC.
//   - if_id_valid=0, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR, skid cleared.
//   - imem_read forced 0 during any cycle with rst=1; an in-flight request is abandoned (memory is reset too).
//  States:
//   - FETCH   : imem_read=1, imem_address=pc_q.
//   - HOLD    : imem_read=0; skid holds {pc_q, rdata} because IF/ID was full and stalled.
//   - DISCARD : imem_read=1, imem_address=stale_addr; the response is dropped.
//  Consume: cons = if_id_valid & id_ready. IF/ID "free" = !if_id_valid | cons.
//  Transition priority: rst > redirect > normal.
//  FETCH, imem_resp=1, free:
//   - IF/ID <= {pc_q, rdata}, valid=1; pc_q += 4; stay FETCH.
//   - Latency: resp at cycle t -> if_id_valid at t+1; back-to-back responses give one instr/cycle.
//  FETCH, imem_resp=1, !free:
//   - skid <= {pc_q, rdata}; -> HOLD.
//  FETCH, imem_resp=0:
//   - hold; valid <= valid & !cons.
//  HOLD, id_ready=1: IF/ID <= skid; pc_q += 4; -> FETCH.
//  HOLD, id_ready=0: no change.
//  Redirect, any state:
//   - IF/ID valid<=0, instr<=NOP_INSTR; skid invalidated; pc_q <= redirect_pc.
//   - FETCH with imem_resp=0: stale_addr <= pc_q; -> DISCARD (address held stable for the memory).
//   - FETCH with imem_resp=1 in the same cycle: data dropped; -> FETCH at redirect_pc next cycle.
//   - HOLD: -> FETCH.
//   - DISCARD: pc_q updated to the newest target; stay DISCARD.
//  DISCARD, imem_resp=1: data dropped, IF/ID untouched; -> FETCH (new address next cycle).
//  A redirect never lets a wrong-path instruction reach IF/ID. No instruction is lost or duplicated under stall.
//  Arithmetic: pc_q+4 is modulo 2^32 (wrap allowed, no trap). redirect_pc is used unmodified.
// STRUCTURE
//  - rv32i_types package gains:
//    - fetch_state_t enum {FETCH, HOLD, DISCARD}
//    - localparam NOP_INSTR
//    - reuses rv32i_word and rv32i_opcode.
//  - Sub-module if_id_reg: 64-bit {pc, instr} register with load/flush/valid, flush value {RESET_PC?pc, NOP_INSTR}.
//  - FSM, pc_q, skid and stale_addr stay in fetch_stage.
// TESTING
//  1. Reset then resp every cycle (1-cycle mem), id_ready=1 -> if_id_pc 6000_0000, 6000_0004, 6000_0008 on consecutive cycles.
//  2. IF/ID valid, id_ready=0, resp arrives -> imem_read=0 next cycle; id_ready=1 after 3 cycles -> held instr delivered once, then next fetch at +4.
//  3. Redirect to 6000_0100 while waiting; resp after 3 cycles:
//     - imem_address stays old until resp; data dropped; next imem_address=6000_0100.
//     - if_id_valid=0 throughout.
//  4. Redirect coincident with imem_resp -> data dropped; imem_address=6000_0100 next cycle; if_id_valid=0.
//  5. Redirect in HOLD -> skid discarded; FETCH at redirect_pc; the stalled instr is never presented.
//  6. rst mid-request, then mem reset ->
//     - if_id_valid=0, if_id_instr=0000_0013, opcode=op_imm.
//     - first imem_address=6000_0000; pc wrap check: redirect_pc=FFFF_FFFC -> next fetch 0000_0000.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word, base opcodes, fetch FSM states and the IF/ID entry layout.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    HOLD    = 2'b01,
    DISCARD = 2'b10
  } fetch_state_t;

  // addi x0,x0,0
  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc, instr} plus valid; load wins over flush, flush keeps pc and inserts a NOP.
module if_id_reg
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h6000_0000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t load_dat,
  output logic   valid,
  output if_id_t entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= 1'b0;
      entry.pc    <= RESET_PC;
      entry.instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_dat;
    end else if (flush) begin
      valid       <= 1'b0;
      entry.instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem reads, absorbs one response in a skid while
// decode stalls, and drops wrong-path responses after an EX redirect. IF/ID feeds decode directly.
module fetch_stage
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output rv32i_opcode opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam logic [1:0] S_FETCH   = FETCH;
  localparam logic [1:0] S_HOLD    = HOLD;
  localparam logic [1:0] S_DISCARD = DISCARD;

  logic [1:0] state_q, state_d;
  rv32i_word  pc_q, pc_d;
  rv32i_word  stale_addr_q, stale_addr_d;
  if_id_t     skid_q, skid_d;
  if_id_t     entry;

  logic   cons, free;
  logic   id_load, id_flush;
  if_id_t id_load_dat;

  assign cons = if_id_valid & id_ready;
  assign free = ~if_id_valid | cons;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    skid_d       = skid_q;
    id_load      = 1'b0;
    id_load_dat  = '{pc: pc_q, instr: imem_rdata};

    if (redirect) begin
      pc_d   = redirect_pc;
      skid_d = '0;
      case (state_q)
        S_FETCH: begin
          if (!imem_resp) begin
            // Memory still owes a response for pc_q; keep its address stable until it arrives.
            stale_addr_d = pc_q;
            state_d      = S_DISCARD;
          end
        end
        S_HOLD:    state_d = S_FETCH;
        // A response landing with the redirect retires the stale request.
        S_DISCARD: state_d = imem_resp ? S_FETCH : S_DISCARD;
        default:   state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_resp) begin
            if (free) begin
              id_load = 1'b1;
              pc_d    = pc_q + 32'd4;
            end else begin
              skid_d  = '{pc: pc_q, instr: imem_rdata};
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_load     = 1'b1;
            id_load_dat = skid_q;
            pc_d        = pc_q + 32'd4;
            state_d     = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_resp) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign id_flush = redirect | (cons & ~id_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= RESET_PC;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      skid_q       <= skid_d;
    end
  end

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (id_load),
    .flush    (id_flush),
    .load_dat (id_load_dat),
    .valid    (if_id_valid),
    .entry    (entry)
  );

  assign imem_read    = ~rst & (state_q != S_HOLD);
  assign imem_address = (state_q == S_DISCARD) ? stale_addr_q : pc_q;

  assign if_id_pc    = entry.pc;
  assign if_id_instr = entry.instr;
  assign opcode      = rv32i_opcode'(entry.instr[6:0]);
  assign funct3      = entry.instr[14:12];
  assign funct7      = entry.instr[31:25];

endmodule
